// File: rtl/oram_pkg.sv
// rtl/oram_pkg.sv - shared ORAM store constants, state encoding and row address helper
package oram_pkg;

    localparam int ORAM_ADDR_W = 8;
    localparam int MXU_ROWS    = 16;
    localparam int MXU_ROW_W   = 128;
    localparam int ROW_CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_WRITE     = 2'd2,
        ST_DONE      = 2'd3
    } store_state_e;

    // Entry address of row 'cnt' walking up or down from 'base'; wraps modulo 2^ORAM_ADDR_W.
    function automatic logic [ORAM_ADDR_W-1:0] row_entry_addr(
        input logic [ORAM_ADDR_W-1:0] base,
        input logic                   dir,
        input logic [ROW_CNT_W-1:0]   cnt
    );
        logic [ORAM_ADDR_W-1:0] offset;
        offset = {{(ORAM_ADDR_W-ROW_CNT_W){1'b0}}, cnt};
        return dir ? (base + offset) : (base - offset);
    endfunction

endpackage

// File: rtl/oram_store_seq_if.sv
// rtl/oram_store_seq_if.sv - IDU command, MXU tile and ORAM write bus bundle
interface oram_store_seq_if;
    import oram_pkg::*;

    logic                          idu_oram_vld;
    logic                          idu_oram_rdy;
    logic [11:0]                   idu_oram_start_addr;
    logic                          idu_oram_row_dir;
    logic [3:0]                    idu_oram_row_len;
    logic                          mxu_data_rdy;
    logic [MXU_ROWS*MXU_ROW_W-1:0] mxu_row_data;
    logic                          oram_cen;
    logic                          oram_wen;
    logic [ORAM_ADDR_W-1:0]        oram_addr;
    logic [MXU_ROW_W-1:0]          oram_din;
    logic                          oram_done;
    logic                          oram_busy;

    // Command/data source side (IDU + MXU, and the observer of the ORAM port).
    modport master (
        output idu_oram_vld, idu_oram_start_addr, idu_oram_row_dir, idu_oram_row_len,
        output mxu_data_rdy, mxu_row_data,
        input  idu_oram_rdy, oram_cen, oram_wen, oram_addr, oram_din, oram_done, oram_busy
    );

    // Store sequencer side.
    modport slave (
        input  idu_oram_vld, idu_oram_start_addr, idu_oram_row_dir, idu_oram_row_len,
        input  mxu_data_rdy, mxu_row_data,
        output idu_oram_rdy, oram_cen, oram_wen, oram_addr, oram_din, oram_done, oram_busy
    );

endinterface

// File: rtl/oram_row_addr_gen.sv
// rtl/oram_row_addr_gen.sv - wrapped per-row entry address from base, direction and row counter
module oram_row_addr_gen
    import oram_pkg::*;
(
    input  logic [ORAM_ADDR_W-1:0] base_i,
    input  logic                   dir_i,
    input  logic [ROW_CNT_W-1:0]   cnt_i,
    output logic [ORAM_ADDR_W-1:0] addr_o
);

    // Pure combinational offset; wrap comes for free from the fixed result width.
    assign addr_o = row_entry_addr(base_i, dir_i, cnt_i);

endmodule

// File: rtl/oram_store_seq.sv
// rtl/oram_store_seq.sv - captures one MXU result tile and writes it into ORAM one row per cycle
module oram_store_seq
    import oram_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    oram_store_seq_if.slave  bus
);

    localparam int ROWS   = MXU_ROWS;
    localparam int ROW_W  = MXU_ROW_W;
    localparam int ADDR_W = ORAM_ADDR_W;

    store_state_e             state_q;
    logic [ROW_CNT_W-1:0]     cnt_q;
    logic [ADDR_W-1:0]        base_q;
    logic                     dir_q;
    logic [ROW_CNT_W-1:0]     len_q;
    logic [ROWS*ROW_W-1:0]    tile_q;
    logic [ADDR_W-1:0]        addr_hold_q;
    logic [ROW_W-1:0]         din_hold_q;

    logic [ADDR_W-1:0]        row_addr_d;
    logic [ROW_W-1:0]         row_din_d;
    logic                     writing;
    logic [3:0]               unused_addr_lsb;

    // The byte offset within an entry has no meaning for a whole-row store.
    assign unused_addr_lsb = bus.idu_oram_start_addr[3:0];

    oram_row_addr_gen u_addr_gen (
        .base_i (base_q),
        .dir_i  (dir_q),
        .cnt_i  (cnt_q),
        .addr_o (row_addr_d)
    );

    assign row_din_d = tile_q[cnt_q*ROW_W +: ROW_W];
    assign writing   = (state_q == ST_WRITE);

    // Command accept, tile capture, row sequencing and last-written address/data hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            base_q      <= '0;
            dir_q       <= 1'b0;
            len_q       <= '0;
            addr_hold_q <= '0;
            din_hold_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.idu_oram_vld) begin
                        base_q  <= bus.idu_oram_start_addr[11:4];
                        dir_q   <= bus.idu_oram_row_dir;
                        len_q   <= bus.idu_oram_row_len;
                        cnt_q   <= '0;
                        state_q <= ST_WAIT_DATA;
                    end
                end
                ST_WAIT_DATA: begin
                    if (bus.mxu_data_rdy) begin
                        tile_q  <= bus.mxu_row_data;
                        state_q <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    addr_hold_q <= row_addr_d;
                    din_hold_q  <= row_din_d;
                    if (cnt_q == len_q) begin
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Tile register is only ever read while WRITE, after a capture, so it needs no reset.
    assign bus.oram_cen     = writing;
    assign bus.oram_wen     = writing;
    assign bus.oram_addr    = writing ? row_addr_d : addr_hold_q;
    assign bus.oram_din     = writing ? row_din_d  : din_hold_q;
    assign bus.oram_done    = (state_q == ST_DONE);
    assign bus.oram_busy    = (state_q != ST_IDLE);
    assign bus.idu_oram_rdy = (state_q == ST_IDLE);

endmodule

// File: doc/oram_store_seq.md
Name: oram_store_seq

Overview:
- Downstream neighbour of the LSU load path. Captures one 16-row int8 result tile from the MXU and writes it into ORAM, one row per cycle, through the single-port mem_wrapper.
- Driven by IDU store-to-ORAM commands with a valid/ready handshake.
- Signals completion so the IDU can retire the instruction or release a WFI.

Parameters:
- ROWS, 16, number of MXU result rows per tile.
- ROW_W, 128, bits per row (16 x int8).
- ADDR_W, 8, ORAM entry address width (one entry = one row).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- idu_oram_vld  in  1  store command valid.
- idu_oram_rdy  out  1  command accepted when vld & rdy.
- idu_oram_start_addr  in  12  byte address; bits [11:4] give the entry address, bits [3:0] are ignored.
- idu_oram_row_dir  in  1  1 = increment the address per row, 0 = decrement.
- idu_oram_row_len  in  4  rows to write minus 1 (0 -> 1 row, 15 -> 16 rows).
- mxu_data_rdy  in  1  one-cycle pulse: the tile on mxu_row_data is valid.
- mxu_row_data  in  ROWS*ROW_W  row i occupies bits [i*ROW_W +: ROW_W].
- oram_cen  out  1  ORAM access enable.
- oram_wen  out  1  ORAM write enable.
- oram_addr  out  ADDR_W  ORAM entry address.
- oram_din  out  ROW_W  write data.
- oram_done  out  1  one-cycle pulse after the last row is written.
- oram_busy  out  1  high in any state except IDLE.

Behaviour:
- States: IDLE, WAIT_DATA, WRITE, DONE.
- Reset: state = IDLE; row counter, latched address, direction and length = 0. Outputs at reset: oram_cen = 0, oram_wen = 0, oram_addr = 0, oram_din = 0, oram_done = 0, oram_busy = 0, idu_oram_rdy = 1.
- Reset mid-operation: the write is abandoned within one cycle and no further ORAM writes occur.
- IDLE:
  - idu_oram_rdy = 1.
  - On vld: latch start_addr[11:4], row_dir and row_len; row counter = 0; go to WAIT_DATA.
  - mxu_data_rdy in IDLE is ignored. No data is captured.
- WAIT_DATA:
  - rdy = 0.
  - On mxu_data_rdy: latch all ROWS rows into the tile register and go to WRITE.
  - Waits indefinitely; there is no timeout.
- WRITE, one row per cycle:
  - oram_cen = 1, oram_wen = 1.
  - oram_din = tile[row counter].
  - oram_addr = base + row counter when dir = 1, base - row counter when dir = 0.
  - Address arithmetic is modulo 2^ADDR_W (wrap: 0xFF + 1 -> 0x00, 0x00 - 1 -> 0xFF).
  - Outputs are driven combinationally from the registered state and counter.
  - The first write occurs in the cycle after the capture.
  - When counter == row_len: go to DONE. Otherwise counter + 1.
  - Exactly row_len + 1 writes are performed.
- DONE:
  - oram_done = 1 for one cycle, then go to IDLE.
  - In the cycle after DONE, rdy = 1.
- Outside WRITE: oram_cen = oram_wen = 0. oram_addr and oram_din hold their last values.
- mxu_data_rdy during WRITE or DONE is ignored and does not overwrite the tile register.
- idu_oram_vld is ignored unless in IDLE.
- Latency:
  - Command accept -> first write: 1 + (wait for data) + 1 cycles.
  - Data capture -> done pulse: row_len + 2 cycles.

Decomposition:
- Shared package oram_pkg holds:
  - ORAM_ADDR_W = 8, MXU_ROWS = 16, MXU_ROW_W = 128.
  - State encoding: IDLE = 2'd0, WAIT_DATA = 2'd1, WRITE = 2'd2, DONE = 2'd3.
- One natural sub-module, oram_row_addr_gen: base, dir and counter in; wrapped entry address out. It is reusable by the LSU iram/wram address paths.
- The tile register and the FSM stay in the top module.

Test Plan:
- Full tile: start_addr = 0x120, dir = 1, len = 15; row i = {16{i[7:0]}}; data_rdy pulse -> 16 writes to addr 0x12..0x21, din = row i; done one cycle after the last write; no gap cycles.
- Decrement with wrap: start_addr = 0x010, dir = 0, len = 3 -> addr 0x01, 0x00, 0xFF, 0xFE; cen/wen = 1 for exactly 4 cycles.
- Single row: len = 0, start_addr = 0xFF0 -> one write at addr 0xFF with row 0; done 2 cycles after data_rdy.
- Ignored events:
  - data_rdy in IDLE -> no ORAM activity.
  - Second data_rdy during WRITE -> the remaining rows come from the first tile.
  - vld during WRITE -> rdy stays 0; the command is accepted only after DONE.
- Reset mid-write: assert rst on the 3rd WRITE cycle -> next cycle cen = wen = 0, busy = 0, rdy = 1, done never pulses. A new command then completes normally.
- Back-to-back: vld held high -> the second command is accepted in the cycle after the done pulse; busy is low for exactly that one cycle.
